// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and constants for the two-input round-robin mux arbiter
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic SEL_IN0      = 1'b0;
  localparam logic SEL_IN1      = 1'b1;
  // in0 wins the first tie after reset because it is "not the last one served"
  localparam logic LAST_SEL_RST = SEL_IN1;

  function automatic arb_state_e gnt_state(input logic sel);
    return (sel == SEL_IN1) ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/mux_out_reg.sv
// rtl/mux_out_reg.sv - one-entry valid/ready register stage feeding the consumer
module mux_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             space
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  // Drain and load may coincide, which sustains one word per cycle
  assign space = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - two-input round-robin arbiter with burst cap driving a 2:1 mux select
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             select,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_e       state_q, state_d;
  logic             select_q, select_d;
  logic             last_sel_q, last_sel_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             space;
  logic             xfer0, xfer1, load;
  logic [WIDTH-1:0] load_data;
  logic             cnt_last;
  logic             cur_sel, own_valid, other_valid, idle_gnt;

  // Readies depend only on registers, never on the incoming valids
  assign in0_ready = (state_q == ST_GNT0) && space;
  assign in1_ready = (state_q == ST_GNT1) && space;

  assign xfer0     = in0_valid && in0_ready;
  assign xfer1     = in1_valid && in1_ready;
  assign load      = xfer0 || xfer1;
  assign load_data = xfer1 ? in1_data : in0_data;

  assign cnt_last  = (burst_cnt_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    state_d     = state_q;
    select_d    = select_q;
    last_sel_d  = last_sel_q;
    burst_cnt_d = burst_cnt_q;
    cur_sel     = (state_q == ST_GNT1) ? SEL_IN1 : SEL_IN0;
    own_valid   = (cur_sel == SEL_IN1) ? in1_valid : in0_valid;
    other_valid = (cur_sel == SEL_IN1) ? in0_valid : in1_valid;
    idle_gnt    = (in0_valid && in1_valid) ? !last_sel_q : in1_valid;

    case (state_q)
      ST_IDLE: begin
        if (in0_valid || in1_valid) begin
          state_d     = gnt_state(idle_gnt);
          select_d    = idle_gnt;
          last_sel_d  = idle_gnt;
          burst_cnt_d = '0;
        end
      end

      ST_GNT0, ST_GNT1: begin
        if (own_valid) begin
          // In a grant state ready equals space, so space here means a transfer
          if (space) begin
            if (cnt_last) begin
              burst_cnt_d = '0;
              if (other_valid) begin
                state_d    = gnt_state(!cur_sel);
                select_d   = !cur_sel;
                last_sel_d = !cur_sel;
              end
            end else begin
              burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
          end
        end else begin
          burst_cnt_d = '0;
          if (other_valid) begin
            state_d    = gnt_state(!cur_sel);
            select_d   = !cur_sel;
            last_sel_d = !cur_sel;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      select_q    <= SEL_IN0;
      last_sel_q  <= LAST_SEL_RST;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      select_q    <= select_d;
      last_sel_q  <= last_sel_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign select = select_q;

  mux_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .space     (space)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       in0_valid, in1_valid;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready;
  logic       select;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  int errors = 0;
  int checks = 0;

  mux_rr_arbiter #(
    .WIDTH    (8),
    .MAX_BURST(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .select    (select),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp2 [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                            8'h04, 8'h05, 8'h06, 8'h07, 8'h14, 8'h15, 8'h16, 8'h17};

  initial begin
    int  k, i0, i1;
    logic f0, f1, s;

    rst_n = 1'b0; out_ready = 1'b0;
    in0_valid = 1'b0; in0_data = 8'h00;
    in1_valid = 1'b0; in1_data = 8'h00;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_select",    32'(select),    32'd0);
    chk("rst_in0_ready", 32'(in0_ready), 32'd0);
    chk("rst_in1_ready", 32'(in1_ready), 32'd0);
    rst_n = 1'b1;

    // 1: single word from in0
    in0_valid = 1'b1; in0_data = 8'hA5; out_ready = 1'b1;
    chk("t1_idle_ready", 32'(in0_ready), 32'd0);
    tick();
    chk("t1_select",    32'(select),    32'd0);
    chk("t1_in0_ready", 32'(in0_ready), 32'd1);
    chk("t1_no_out",    32'(out_valid), 32'd0);
    tick();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_data",  32'(out_data),  32'hA5);
    in0_valid = 1'b0;
    tick();
    chk("t1_idle_ready0", 32'(in0_ready), 32'd0);
    chk("t1_drained",     32'(out_valid), 32'd0);

    // 2: both streaming, bursts of 4 interleave (reset so in0 wins the tie)
    rst_n = 1'b0; #2; rst_n = 1'b1;
    k = 0; i0 = 0; i1 = 0;
    for (int c = 0; c < 60 && k < 16; c++) begin
      in0_valid = (i0 < 8); in0_data = 8'(i0);
      in1_valid = (i1 < 8); in1_data = 8'(8'h10 + i1);
      f0 = in0_valid && in0_ready;
      f1 = in1_valid && in1_ready;
      s  = select;
      tick();
      if (f0) i0++;
      if (f1) i1++;
      if (f0 || f1) begin
        chk("t2_select", 32'(s), 32'((k / 4) % 2));
        chk("t2_data", 32'(out_data), 32'(exp2[k]));
        k++;
      end
    end
    chk("t2_word_count", 32'(k), 32'd16);
    in0_valid = 1'b0; in1_valid = 1'b0;

    // 6: idle after burst, select holds
    tick();
    chk("t6_in0_ready", 32'(in0_ready), 32'd0);
    chk("t6_in1_ready", 32'(in1_ready), 32'd0);
    chk("t6_select",    32'(select),    32'd1);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t6_select_hold", 32'(select),    32'd1);
    chk("t6_in1_ready2",  32'(in1_ready), 32'd0);

    // 3: stall under GNT0; stalled cycles must not consume burst budget
    in0_valid = 1'b1; in0_data = 8'h20;
    in1_valid = 1'b1; in1_data = 8'h30;
    tick();
    chk("t3_select", 32'(select), 32'd0);
    tick();
    chk("t3_first", 32'(out_data), 32'h20);
    out_ready = 1'b0; in0_data = 8'h21;
    #1;
    chk("t3_stall_ready", 32'(in0_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_hold_data",  32'(out_data),  32'h20);
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_ready", 32'(in0_ready), 32'd0);
      chk("t3_hold_sel",   32'(select),    32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_resume_ready", 32'(in0_ready), 32'd1);
    tick();
    chk("t3_w21", 32'(out_data), 32'h21);
    in0_data = 8'h22;
    tick();
    chk("t3_w22", 32'(out_data), 32'h22);
    chk("t3_still0", 32'(select), 32'd0);
    in0_data = 8'h23;
    tick();
    chk("t3_w23", 32'(out_data), 32'h23);
    chk("t3_switch_sel", 32'(select),    32'd1);
    chk("t3_in1_ready",  32'(in1_ready), 32'd1);

    // 4: in1 drops after two words, in0 takes over after one switch cycle
    in0_data = 8'h24;
    tick();
    chk("t4_w30", 32'(out_data), 32'h30);
    in1_data = 8'h31;
    tick();
    chk("t4_w31", 32'(out_data), 32'h31);
    in1_valid = 1'b0;
    tick();
    chk("t4_select",    32'(select),    32'd0);
    chk("t4_in0_ready", 32'(in0_ready), 32'd1);
    chk("t4_in1_ready", 32'(in1_ready), 32'd0);
    chk("t4_bubble",    32'(out_valid), 32'd0);
    tick();
    chk("t4_w24", 32'(out_data), 32'h24);
    in0_data = 8'h25;
    tick();
    chk("t4_w25", 32'(out_data), 32'h25);
    in0_data = 8'h26;
    tick();
    chk("t4_w26", 32'(out_data), 32'h26);
    in0_data = 8'h27; in1_valid = 1'b1; in1_data = 8'h32;
    tick();
    chk("t4_w27",        32'(out_data),  32'h27);
    chk("t4_cap_switch", 32'(select),    32'd1);

    // 5: async reset mid-burst with a word held
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    #2; rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_out_data",  32'(out_data),  32'h0);
    chk("t5_in0_ready", 32'(in0_ready), 32'd0);
    chk("t5_in1_ready", 32'(in1_ready), 32'd0);
    chk("t5_select",    32'(select),    32'd0);
    in0_data = 8'h40; in0_valid = 1'b1;
    #3; rst_n = 1'b1;
    tick();
    chk("t5_grant_sel",  32'(select),    32'd0);
    chk("t5_in0_ready2", 32'(in0_ready), 32'd1);
    chk("t5_in1_ready2", 32'(in1_ready), 32'd0);
    tick();
    chk("t5_w40", 32'(out_data), 32'h40);
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Two-input round-robin arbiter that sits directly upstream of the 2:1 mux and drives its select line.
- Accepts two valid/ready request streams and grants one at a time.
- Caps each grant at MAX_BURST transfers.
- Exports the current grant as select, and forwards the granted data through a one-entry registered output stage toward the consumer.

Parameters:
WIDTH, 8, data width of each input and of out_data
MAX_BURST, 4, maximum consecutive transfers per grant before the other requester is offered the grant (>=1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in0_valid  input  1  requester 0 has data
in0_data  input  WIDTH  requester 0 data
in0_ready  output  1  requester 0 transfer accepted this cycle when high with in0_valid
in1_valid  input  1  requester 1 has data
in1_data  input  WIDTH  requester 1 data
in1_ready  output  1  requester 1 transfer accepted this cycle when high with in1_valid
select  output  1  current grant (0 = in0, 1 = in1); drives mux select
out_valid  output  1  out_data holds a word
out_data  output  WIDTH  registered granted word
out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, select=0, last_sel=1 (so in0 wins the first tie).
  - burst_cnt=0, out_valid=0, out_data=0, in0_ready=in1_ready=0.
- FSM states: IDLE, GNT0, GNT1. All state is registered.
- space = !out_valid || out_ready.
- inX_ready = (state==GNTx) && space. This is combinational from registers only; there is no path from inX_valid to inX_ready.
- A transfer occurs when inX_valid && inX_ready.
- IDLE:
  - Only in0_valid -> GNT0. Only in1_valid -> GNT1.
  - Both valid -> grant !last_sel.
  - Neither valid -> stay.
  - On grant: select and last_sel take the granted index, burst_cnt=0.
  - Ready is never high in IDLE, so the first transfer happens 1 cycle after a request arrives.
- GNTx with transfer:
  - If burst_cnt+1 == MAX_BURST: burst_cnt=0, and move to GNT(other) if other_valid, else stay in GNTx (new burst).
  - Otherwise burst_cnt+1.
- GNTx with inX_valid low: move to GNT(other) if other_valid (burst_cnt=0), else IDLE (burst_cnt=0).
- GNTx with inX_valid high but !space: hold the state, burst_cnt and select.
- Output stage:
  - A transfer loads out_data <= inX_data and sets out_valid=1.
  - Otherwise, out_ready clears out_valid. out_data holds its last value.
  - Drain and load in the same cycle are legal, giving one word per cycle sustained.
- Latency: input transfer to out_valid is 1 cycle.
- select changes only on state transitions and holds its last value in IDLE.
- Ordering: words from one requester leave in acceptance order. No word is dropped or duplicated.
- MAX_BURST=1: strict alternation whenever both inputs are valid.
- Reset mid-operation: any held out_data word is discarded, the FSM returns to IDLE and all readies drop in the same cycle.

Decomposition:
- Package mux_arb_pkg holds:
  - the state enum (IDLE, GNT0, GNT1);
  - the select encodings SEL_IN0=0 and SEL_IN1=1;
  - the reset constant for last_sel.
- One natural sub-module, mux_out_reg: the one-entry valid/ready register stage. Parameterised by WIDTH; inputs load/load_data/out_ready; outputs out_valid/out_data/space.

Test Plan:
1. Reset, then in0_valid=1, in0_data=8'hA5, in1_valid=0, out_ready=1 -> cycle1: select=0, in0_ready=1; cycle2: out_valid=1, out_data=A5.
2. Both valid continuously, in0 sends 00..07 and in1 sends 10..17, MAX_BURST=4, out_ready=1 -> output sequence 00,01,02,03,10,11,12,13,04,05,06,07,14,15,16,17; select toggles every 4 transfers.
3. GNT0 active, out_ready=0 for 3 cycles with in0 valid -> out_data holds its first word, in0_ready=0, burst_cnt and select unchanged; when out_ready returns to 1, transfers resume with no loss or duplication.
4. GNT1 with in1_valid dropping after 2 words while in0_valid=1 -> next cycle state=GNT0, select=0, burst_cnt=0; in0 data follows with no bubble beyond the 1-cycle switch.
5. Assert rst_n=0 asynchronously mid-burst while out_valid=1 -> out_valid, in0_ready and in1_ready fall immediately; after release with both inputs valid, in0 is granted first.
6. Both inputs idle after a burst -> state returns to IDLE, select holds its last value, readies stay 0 until the next request.
